// File: rtl/load_store_unit_if.sv
// Word-organised data-memory port between the load/store unit and data memory.
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle load/store stage: decodes SLControl, runs one request/ready
// transfer on the data-memory port and returns an extended load result.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [3:0]           SLControl,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          rdata,
  output logic [1:0]           err_code,
  load_store_unit_if.master    mem
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned CNT_W  = 16;

  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LH  = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b0010;
  localparam logic [3:0] OP_LWU = 4'b0011;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1000;
  localparam logic [3:0] OP_SH  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1010;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_MISALGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         code_q, code_d;
  logic [1:0]         off_q, off_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic [1:0]         err_q, err_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [DATA_W-1:0]  mem_addr_q, mem_addr_d;
  logic [BE_W-1:0]    mem_be_q, mem_be_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;

  logic               legal_c;
  logic               is_store_c;
  size_e              size_c;
  logic               misal_c;
  logic [BE_W-1:0]    be_c;
  logic [DATA_W-1:0]  wdata_rep_c;
  logic [7:0]         lane_b_c;
  logic [15:0]        lane_h_c;
  logic [DATA_W-1:0]  load_ext_c;

  // Decode of the incoming access code and its alignment
  always_comb begin
    legal_c    = 1'b1;
    is_store_c = 1'b0;
    size_c     = SZ_BYTE;
    case (SLControl)
      OP_LB, OP_LBU:  size_c = SZ_BYTE;
      OP_LH, OP_LHU:  size_c = SZ_HALF;
      OP_LW, OP_LWU:  size_c = SZ_WORD;
      OP_SB: begin size_c = SZ_BYTE; is_store_c = 1'b1; end
      OP_SH: begin size_c = SZ_HALF; is_store_c = 1'b1; end
      OP_SW: begin size_c = SZ_WORD; is_store_c = 1'b1; end
      default:        legal_c = 1'b0;
    endcase

    misal_c = ((size_c == SZ_HALF) && addr[0]) ||
              ((size_c == SZ_WORD) && (addr[1:0] != 2'b00));

    case (size_c)
      SZ_BYTE: be_c = BE_W'(4'b0001 << addr[1:0]);
      SZ_HALF: be_c = BE_W'(4'b0011 << {addr[1], 1'b0});
      default: be_c = 4'b1111;
    endcase

    case (size_c)
      SZ_BYTE: wdata_rep_c = {4{wdata[7:0]}};
      SZ_HALF: wdata_rep_c = {2{wdata[15:0]}};
      default: wdata_rep_c = wdata;
    endcase
  end

  // Lane select and extension of the returned word, using the latched op
  always_comb begin
    lane_b_c = 8'(mem.mem_rdata >> {off_q, 3'b000});
    lane_h_c = 16'(mem.mem_rdata >> {off_q[1], 4'b0000});
    case (code_q)
      OP_LB:         load_ext_c = {{24{lane_b_c[7]}}, lane_b_c};
      OP_LBU:        load_ext_c = {24'd0, lane_b_c};
      OP_LH:         load_ext_c = {{16{lane_h_c[15]}}, lane_h_c};
      OP_LHU:        load_ext_c = {16'd0, lane_h_c};
      OP_LW, OP_LWU: load_ext_c = mem.mem_rdata;
      default:       load_ext_c = '0;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    off_d       = off_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rdata_d     = rdata_q;
    err_d       = err_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      S_IDLE: begin
        busy_d    = 1'b0;
        mem_req_d = 1'b0;
        if (start) begin
          if (!legal_c || misal_c) begin
            state_d = S_RESP;
            busy_d  = 1'b1;
            done_d  = 1'b1;
            rdata_d = '0;
            err_d   = legal_c ? ERR_MISALGN : ERR_ILLEGAL;
          end else begin
            state_d     = S_ACCESS;
            busy_d      = 1'b1;
            code_d      = SLControl;
            off_d       = addr[1:0];
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = is_store_c;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_be_d    = be_c;
            mem_wdata_d = wdata_rep_c;
          end
        end
      end

      S_ACCESS: begin
        if (mem.mem_ready) begin
          state_d   = S_RESP;
          mem_req_d = 1'b0;
          done_d    = 1'b1;
          err_d     = ERR_OK;
          rdata_d   = mem_we_q ? '0 : load_ext_c;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          state_d   = S_RESP;
          mem_req_d = 1'b0;
          done_d    = 1'b1;
          err_d     = ERR_TIMEOUT;
          rdata_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RESP: begin
        state_d   = S_IDLE;
        busy_d    = 1'b0;
        mem_req_d = 1'b0;
      end

      default: begin
        state_d   = S_IDLE;
        busy_d    = 1'b0;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      code_q      <= '0;
      off_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rdata_q     <= '0;
      err_q       <= ERR_OK;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign rdata         = rdata_q;
  assign err_code      = err_q;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_be    = mem_be_q;
  assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a behavioural memory-op model.
module tb_load_store_unit;
  localparam int unsigned T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  sl;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic [1:0]  err;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  load_store_unit_if mem ();

  load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .SLControl (sl),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .err_code  (err),
    .mem       (mem.master)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Access-code semantics: legality, direction, byte count, signedness
  function automatic void decode(input logic [3:0] c, output bit legal, output bit st,
                                 output int size, output bit sgn);
    legal = 1'b1; st = 1'b0; size = 1; sgn = 1'b0;
    case (c)
      4'd0:  begin size = 1; sgn = 1'b1; end
      4'd1:  begin size = 2; sgn = 1'b1; end
      4'd2,
      4'd3:  size = 4;
      4'd4:  size = 1;
      4'd5:  size = 2;
      4'd8:  begin size = 1; st = 1'b1; end
      4'd9:  begin size = 2; st = 1'b1; end
      4'd10: begin size = 4; st = 1'b1; end
      default: legal = 1'b0;
    endcase
  endfunction

  // One operation: delay = number of ready-low ACCESS cycles before ready
  task automatic do_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] wd,
                       input int delay, input logic [31:0] word);
    bit legal, st, sgn;
    int size, off, n, exp_err;
    logic [31:0] mask, rep, ld, exp_rd, exp_addr;
    logic [3:0]  exp_be;

    decode(c, legal, st, size, sgn);
    off      = int'(a[1:0]);
    mask     = 32'((64'd1 << (8 * size)) - 64'd1);
    exp_be   = 4'(((1 << size) - 1) << off);
    exp_addr = a & ~32'd3;
    rep = '0;
    for (int k = 0; k < 4 / size; k++) rep |= (wd & mask) << (8 * size * k);
    ld = (word >> (8 * off)) & mask;
    if (sgn && ld[8 * size - 1]) ld |= ~mask;
    if (!legal)                exp_err = 2;
    else if ((off % size) != 0) exp_err = 1;
    else if (delay <= int'(T))  exp_err = 0;
    else                        exp_err = 3;
    exp_rd = (exp_err == 0 && !st) ? ld : 32'd0;

    start = 1'b1; sl = c; addr = a; wdata = wd;
    mem.mem_ready = 1'($urandom); mem.mem_rdata = $urandom;
    check("idle_busy", 32'(busy), 32'd0);
    step;
    start = 1'b0; addr = $urandom; wdata = $urandom; sl = 4'($urandom);

    if (exp_err == 1 || exp_err == 2) begin
      check("err_done", 32'(done), 32'd1);
      check("err_code", 32'(err), 32'(exp_err));
      check("err_rdata", rdata, 32'd0);
      check("err_req", 32'(mem.mem_req), 32'd0);
      step;
      check("err_idle_done", 32'(done), 32'd0);
      check("err_idle_busy", 32'(busy), 32'd0);
      check("err_idle_req", 32'(mem.mem_req), 32'd0);
      return;
    end

    n = (delay <= int'(T)) ? delay + 1 : int'(T) + 1;
    for (int i = 0; i < n; i++) begin
      check("acc_req", 32'(mem.mem_req), 32'd1);
      check("acc_busy", 32'(busy), 32'd1);
      check("acc_done", 32'(done), 32'd0);
      check("acc_we", 32'(mem.mem_we), 32'(st));
      check("acc_addr", mem.mem_addr, exp_addr);
      check("acc_be", 32'(mem.mem_be), 32'(exp_be));
      if (st) check("acc_wdata", mem.mem_wdata, rep);
      mem.mem_ready = (i == delay);
      mem.mem_rdata = (i == delay) ? word : $urandom;
      if ($urandom_range(0, 3) == 0) begin
        start = 1'b1; sl = 4'($urandom); addr = $urandom;
      end
      step;
      start = 1'b0;
    end

    mem.mem_ready = 1'($urandom);
    mem.mem_rdata = $urandom;
    check("resp_done", 32'(done), 32'd1);
    check("resp_busy", 32'(busy), 32'd1);
    check("resp_err", 32'(err), 32'(exp_err));
    check("resp_rdata", rdata, exp_rd);
    check("resp_req", 32'(mem.mem_req), 32'd0);
    if ($urandom_range(0, 1) == 1) begin
      start = 1'b1; sl = 4'd2; addr = 32'h40;
    end
    step;
    start = 1'b0;
    mem.mem_ready = 1'b0;
    check("post_done", 32'(done), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
    check("post_req", 32'(mem.mem_req), 32'd0);
    check("post_rdata_hold", rdata, exp_rd);
  endtask

  function automatic logic [3:0] pick_code();
    logic [3:0] legal_codes [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10};
    if ($urandom_range(0, 7) == 0) return 4'($urandom);
    return legal_codes[$urandom_range(0, 8)];
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; sl = '0; addr = '0; wdata = '0;
    mem.mem_ready = 1'b0; mem.mem_rdata = '0;
    step; step;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_req", 32'(mem.mem_req), 32'd0);
    check("rst_we", 32'(mem.mem_we), 32'd0);
    check("rst_be", 32'(mem.mem_be), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_addr", mem.mem_addr, 32'd0);
    check("rst_wdata", mem.mem_wdata, 32'd0);
    rst = 1'b0;
    step;

    do_op(4'd0, 32'h103, 32'h0, 0, 32'h80FF_1234);
    do_op(4'd4, 32'h103, 32'h0, 0, 32'h80FF_1234);
    do_op(4'd9, 32'h202, 32'hDEAD_BEEF, 3, 32'h0);
    do_op(4'd2, 32'h101, 32'h0, 0, 32'h0);
    do_op(4'd15, 32'h100, 32'h0, 0, 32'h0);
    do_op(4'd10, 32'h300, 32'h1234_5678, 1000, 32'h0);
    do_op(4'd1, 32'h10E, 32'h0, int'(T), 32'h8001_7FFF);

    // Reset on the second ACCESS cycle discards the op with no completion
    start = 1'b1; sl = 4'd10; addr = 32'h500; wdata = 32'hCAFE_F00D;
    step;
    start = 1'b0;
    check("rmid_req1", 32'(mem.mem_req), 32'd1);
    step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    check("rmid_req", 32'(mem.mem_req), 32'd0);
    check("rmid_busy", 32'(busy), 32'd0);
    check("rmid_done", 32'(done), 32'd0);
    step;
    check("rmid_done2", 32'(done), 32'd0);
    do_op(4'd2, 32'h0, 32'h0, 1, 32'h1357_9BDF);

    for (int t = 0; t < 300; t++) begin
      logic [3:0] c;
      int d;
      c = pick_code();
      d = ($urandom_range(0, 9) == 0) ? int'(T) + 1 + int'($urandom_range(0, 3))
                                      : int'($urandom_range(0, T));
      do_op(c, $urandom, $urandom, d, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle data-memory access stage sitting directly downstream of the control unit's load/store decode. It consumes the 4-bit `SLControl` code, the ALU-computed effective address and the store operand. It drives a word-organised data-memory port with a request/ready handshake and byte enables. It returns an aligned, sign- or zero-extended load result, plus a stall signal for the core.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum number of `mem_ready`-low cycles tolerated in ACCESS before aborting. Legal range 1..65535.

Ports:
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `start` input 1: single-cycle pulse meaning "execute memory op now". Ignored unless the block is idle.
- `SLControl` input 4: access code. Sampled with `start`.
- `addr` input 32: byte effective address. Sampled with `start`.
- `wdata` input 32: store operand (rs2). Sampled with `start`.
- `busy` output 1: high while an operation is in flight; the core stalls on it.
- `done` output 1: one-cycle completion pulse.
- `rdata` output 32: extended load result. Valid while `done`=1; holds its value afterwards.
- `err_code` output 2: 00 ok, 01 misaligned, 10 illegal code, 11 timeout. Valid with `done`.
- `mem_req` output 1: memory request.
- `mem_we` output 1: 1 for a store, 0 for a load.
- `mem_addr` output 32: word address, `{addr[31:2],2'b00}`.
- `mem_be` output 4: byte lane enables.
- `mem_wdata` output 32: lane-replicated store data.
- `mem_ready` input 1: memory accepted the store or returned load data this cycle.
- `mem_rdata` input 32: load word. Valid when `mem_ready`=1.

## Operation
SLControl codes:
- 0000 lb, 0001 lh, 0010 lw, 0011 lwu (same as lw), 0100 lbu, 0101 lhu.
- 1000 sb, 1001 sh, 1010 sw.
- Any other code is illegal.

Alignment rules:
- Halfword accesses require `addr[0]`=0.
- Word accesses require `addr[1:0]`=00.
- Byte accesses are always aligned.

Byte enables and write data:
- `mem_be`: byte = `4'b0001<<addr[1:0]`; half = `4'b0011<<{addr[1],1'b0}`; word = `4'b1111`.
- The same `mem_be` is driven for loads.
- `mem_wdata`: sb = `{4{wdata[7:0]}}`; sh = `{2{wdata[15:0]}}`; sw = `wdata`.

Load extraction:
- The selected lane is taken from `mem_rdata`.
- lb and lh sign-extend to 32 bits; lbu and lhu zero-extend.
- `rdata` = 0 for stores and for errored operations.

State machine (registered):
- IDLE: `busy`=0.
  - `start` with a legal, aligned op → ACCESS. Operands are latched and the timeout counter is cleared.
  - `start` with an illegal or misaligned op → RESP with the err code set. No `mem_req` is ever raised.
- ACCESS: `mem_req`=1, `busy`=1. `mem_we`, `mem_addr`, `mem_be` and `mem_wdata` are held stable from latched operands.
  - `mem_ready`=1 → capture and extend the load data, then → RESP with err 00.
  - Otherwise the counter increments. If the counter equals `TIMEOUT_CYCLES` while `mem_ready`=0 → RESP with err 11.
- RESP: `done`=1, `busy`=1, `mem_req`=0 → IDLE.
- Illegal state encodings → IDLE.

Boundary conditions:
- `start` while not IDLE: ignored, no queuing.
- `start` in the RESP cycle: ignored.
- `mem_ready` while not in ACCESS: ignored.
- `rst` mid-ACCESS: `mem_req` drops at the same edge. No `done` pulse is produced, and the pending op is discarded.

## Timing
Reset values:
- State IDLE.
- `busy`, `done`, `mem_req` and `mem_we` = 0.
- `mem_be` = 0, `err_code` = 00, `rdata`, `mem_addr` and `mem_wdata` = 0.

Latency:
- `start` high in cycle 0 → `mem_req` high in cycle 1.
- If `mem_ready` is high in cycle k (k≥1), `done` is high in cycle k+1. Best case is a 2-cycle op.
- Error path: `done` with the err code in cycle 1; `mem_req` never asserts.
- Timeout: `done` with err 11 appears `TIMEOUT_CYCLES`+1 cycles after `mem_req` rose.

Handshake:
- The request is held unchanged until the ready or timeout cycle.
- Exactly one transfer occurs per accepted `start`.
- All outputs are registered; no combinational path from `mem_ready` to `done`.

## Test plan
- Load byte, sign path: lb at addr 0x103, `mem_rdata`=0x80FF_1234 with ready in cycle 1 → `mem_be`=1000, `mem_addr`=0x100, `done` in cycle 2, `rdata`=0xFFFF_FF80. Repeat as lbu → `rdata`=0x0000_0080.
- Store half: sh at addr 0x202, `wdata`=0xDEAD_BEEF, ready delayed 3 cycles → `mem_we`=1, `mem_be`=1100, `mem_wdata`=0xBEEF_BEEF held stable through the wait, `done` err 00, `rdata`=0.
- Misaligned and illegal: lw at 0x101 → `done` in cycle 1 with err 01, `mem_req` never high. SLControl=1111 → err 10.
- Timeout: `TIMEOUT_CYCLES`=4, sw with `mem_ready` held 0 → `mem_req` high for 5 cycles, then `done` with err 11, then back to IDLE.
- Back-to-back and ignored start: second `start` during ACCESS is ignored. A new `start` in the cycle after `done` is accepted and `mem_req` reasserts one cycle later.
- Reset mid-access: `rst` asserted on the second ACCESS cycle → next cycle `mem_req`=0 and `busy`=0, no `done` pulse, and a following lw at 0x0 completes normally.
